// File: rtl/punc_datapath_gen2_if.sv
// Memory bus between the PUnC gen-2 datapath (master) and the system bus fabric (slave).
// Request/acknowledge handshake; address, write flag and write data stay stable while mem_req is high.
interface punc_datapath_gen2_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_ack;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/punc_datapath_gen2.sv
// PUnC gen-2 datapath: register file, PC/IR/NZP, a request/ack memory sequencer with MDR,
// and a serial shift-add multiplier; the controller stalls on busy.
module punc_datapath_gen2 #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_clr,
  input  logic             pc_inc,
  input  logic             pc_ld,
  input  logic [1:0]       pc_sel,
  input  logic             ir_ld,
  input  logic             mem_start,
  input  logic             mem_we_sel,
  input  logic [1:0]       mem_addr_sel,
  input  logic             rf_w_en,
  input  logic             rf_w_addr_sel,
  input  logic [2:0]       rf_w_data_sel,
  input  logic             rf_r0_addr_sel,
  input  logic             nzp_ld,
  input  logic [2:0]       alu_op,
  input  logic             alu_b_sel,
  input  logic             alu_start,
  output logic [WIDTH-1:0] ir_out,
  output logic             nzp_true,
  output logic             busy,
  output logic             mem_done,
  output logic             alu_done,
  punc_datapath_gen2_if.master bus,
  input  logic [2:0]       rf_debug_addr,
  output logic [WIDTH-1:0] rf_debug_data,
  output logic [WIDTH-1:0] pc_debug_data
);
  // state  | meaning
  // M_IDLE | no memory transaction; mem_start latches address, we flag and write data
  // M_REQ  | mem_req high, waiting for mem_ack
  // M_RESP | mem_done pulse; MDR holds read data
  // MIDLE  | multiplier idle; alu_start with MUL loads operands
  // MRUN   | one shift-add step per cycle for WIDTH cycles
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_RESP} mem_state_t;
  typedef enum logic {MIDLE, MRUN} mul_state_t;

  localparam int         CNT_W  = $clog2(WIDTH + 1);
  localparam bit         MUL_ON = (MUL_EN != 0);
  localparam logic [2:0] OP_PASSA = 3'd0, OP_ADD = 3'd1, OP_AND = 3'd2, OP_NOT = 3'd3, OP_MUL = 3'd4;

  logic [WIDTH-1:0] pc, ir, mdr, mul_res;
  logic [WIDTH-1:0] rf [0:7];
  logic [2:0]       nzp;
  logic [WIDTH-1:0] sext9, sext11, sext6, sext5;
  logic [WIDTH-1:0] r0_data, r1_data, alu_b, alu_out, rf_wdata, pc_plus9, pc_next, addr_src;
  logic [2:0]       r0_addr, w_addr;

  assign sext9  = {{(WIDTH-9){ir[8]}},   ir[8:0]};
  assign sext11 = {{(WIDTH-11){ir[10]}}, ir[10:0]};
  assign sext6  = {{(WIDTH-6){ir[5]}},   ir[5:0]};
  assign sext5  = {{(WIDTH-5){ir[4]}},   ir[4:0]};

  assign r0_addr  = rf_r0_addr_sel ? ir[2:0] : ir[11:9];
  assign w_addr   = rf_w_addr_sel ? ir[11:9] : 3'd7;
  assign r0_data  = rf[r0_addr];
  assign r1_data  = rf[ir[8:6]];
  assign alu_b    = alu_b_sel ? sext5 : r0_data;
  assign pc_plus9 = pc + sext9;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_PASSA: alu_out = alu_b;
      OP_ADD:   alu_out = r1_data + alu_b;
      OP_AND:   alu_out = r1_data & alu_b;
      OP_NOT:   alu_out = ~r1_data;
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    rf_wdata = '0;
    case (rf_w_data_sel)
      3'd0:    rf_wdata = alu_out;
      3'd1:    rf_wdata = pc_plus9;
      3'd2:    rf_wdata = mdr;
      3'd3:    rf_wdata = pc;
      3'd4:    rf_wdata = mul_res;
      default: rf_wdata = '0;
    endcase
  end

  always_comb begin
    pc_next = pc_plus9;
    case (pc_sel)
      2'd0: pc_next = pc_plus9;
      2'd1: pc_next = pc + sext11;
      2'd2: pc_next = r1_data;
      2'd3: pc_next = alu_out;
    endcase
  end

  always_comb begin
    addr_src = pc;
    case (mem_addr_sel)
      2'd0: addr_src = pc;
      2'd1: addr_src = pc_plus9;
      2'd2: addr_src = r0_data;
      2'd3: addr_src = r1_data + sext6;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (rf_w_en) begin
      rf[w_addr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      ir  <= '0;
      nzp <= 3'b010;
    end else begin
      if (pc_clr)      pc <= '0;
      else if (pc_inc) pc <= pc + WIDTH'(1);
      else if (pc_ld)  pc <= pc_next;
      if (ir_ld) ir <= mdr;
      if (nzp_ld) nzp <= {rf_wdata[WIDTH-1], rf_wdata == '0, !rf_wdata[WIDTH-1] && rf_wdata != '0};
    end
  end

  assign nzp_true = (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);

  mem_state_t        mem_state, mem_next;
  logic              mem_req_c, mem_done_c, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;

  always_ff @(posedge clk) begin
    if (rst) mem_state <= M_IDLE;
    else     mem_state <= mem_next;
  end

  always_comb begin
    mem_next   = mem_state;
    mem_req_c  = 1'b0;
    mem_done_c = 1'b0;
    case (mem_state)
      M_IDLE: if (mem_start) mem_next = M_REQ;
      M_REQ: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) mem_next = M_RESP;
      end
      M_RESP: begin
        mem_done_c = 1'b1;
        mem_next   = M_IDLE;
      end
      default: mem_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mdr     <= '0;
    end else begin
      if (mem_state == M_IDLE && mem_start) begin
        addr_q  <= ADDR_W'(addr_src);
        wdata_q <= r0_data;
        we_q    <= mem_we_sel;
      end
      if (mem_state == M_REQ && bus.mem_ack && !we_q) mdr <= bus.mem_rdata;
    end
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = we_q & mem_req_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign mem_done      = mem_done_c;

  mul_state_t       mul_state, mul_next;
  logic [WIDTH-1:0] mul_a, mul_b, mul_acc, acc_next;
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_go, mul_last, alu_done_q;

  assign mul_go   = MUL_ON && alu_start && (alu_op == OP_MUL);
  assign mul_last = (mul_cnt == CNT_W'(1));
  assign acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

  always_ff @(posedge clk) begin
    if (rst) mul_state <= MIDLE;
    else     mul_state <= mul_next;
  end

  always_comb begin
    mul_next = mul_state;
    case (mul_state)
      MIDLE:   if (mul_go) mul_next = MRUN;
      MRUN:    if (mul_last) mul_next = MIDLE;
      default: mul_next = MIDLE;
    endcase
  end

  // The result register and done pulse are written on the final step so alu_done lands at WIDTH+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_acc    <= '0;
      mul_cnt    <= '0;
      mul_res    <= '0;
      alu_done_q <= 1'b0;
    end else begin
      alu_done_q <= 1'b0;
      if (mul_state == MIDLE) begin
        if (mul_go) begin
          mul_a   <= r1_data;
          mul_b   <= alu_b;
          mul_acc <= '0;
          mul_cnt <= CNT_W'(WIDTH);
        end
      end else begin
        mul_acc <= acc_next;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
        mul_cnt <= mul_cnt - CNT_W'(1);
        if (mul_last) begin
          mul_res    <= acc_next;
          alu_done_q <= 1'b1;
        end
      end
    end
  end

  assign alu_done      = alu_done_q;
  assign busy          = (mem_state != M_IDLE) | (mul_state == MRUN);
  assign ir_out        = ir;
  assign rf_debug_data = rf[rf_debug_addr];
  assign pc_debug_data = pc;
endmodule

// File: tb/tb_punc_datapath_gen2.sv
// Directed bench for punc_datapath_gen2 (WIDTH=16): reset, memory handshake, store addressing,
// multiplier latency/results, NZP flags, PC sources and reset mid-transaction.
module tb_punc_datapath_gen2;
  logic        clk;
  logic        rst;
  logic        pc_clr, pc_inc, pc_ld;
  logic [1:0]  pc_sel;
  logic        ir_ld, mem_start, mem_we_sel;
  logic [1:0]  mem_addr_sel;
  logic        rf_w_en, rf_w_addr_sel;
  logic [2:0]  rf_w_data_sel;
  logic        rf_r0_addr_sel, nzp_ld;
  logic [2:0]  alu_op;
  logic        alu_b_sel, alu_start;
  logic [15:0] ir_out;
  logic        nzp_true, busy, mem_done, alu_done;
  logic [2:0]  rf_debug_addr;
  logic [15:0] rf_debug_data, pc_debug_data;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] pc_m;
  int          cyc;
  logic        any_done;

  punc_datapath_gen2_if #(.WIDTH(16), .ADDR_W(16)) bus ();

  punc_datapath_gen2 #(.WIDTH(16), .ADDR_W(16), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst),
    .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .mem_start(mem_start), .mem_we_sel(mem_we_sel), .mem_addr_sel(mem_addr_sel),
    .rf_w_en(rf_w_en), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_data_sel(rf_w_data_sel),
    .rf_r0_addr_sel(rf_r0_addr_sel), .nzp_ld(nzp_ld),
    .alu_op(alu_op), .alu_b_sel(alu_b_sel), .alu_start(alu_start),
    .ir_out(ir_out), .nzp_true(nzp_true), .busy(busy), .mem_done(mem_done), .alu_done(alu_done),
    .bus(bus),
    .rf_debug_addr(rf_debug_addr), .rf_debug_data(rf_debug_data), .pc_debug_data(pc_debug_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_txn(input logic we, input logic [1:0] asel, input logic [15:0] rdata,
                         input int lat, input logic [15:0] exp_addr, input logic [15:0] exp_wdata);
    mem_start = 1'b1; mem_we_sel = we; mem_addr_sel = asel;
    tick();
    mem_start = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      chk("req_high", 32'(bus.mem_req), 32'(1));
      chk("req_busy", 32'(busy), 32'(1));
      chk("req_no_done", 32'(mem_done), 32'(0));
      chk("req_addr", 32'(bus.mem_addr), 32'(exp_addr));
      chk("req_we", 32'(bus.mem_we), 32'(we));
      if (we) chk("req_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
      bus.mem_ack = (i == lat);
      bus.mem_rdata = rdata;
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("resp_done", 32'(mem_done), 32'(1));
    chk("resp_req_low", 32'(bus.mem_req), 32'(0));
    tick();
    chk("done_one_cycle", 32'(mem_done), 32'(0));
  endtask

  task automatic load_ir(input logic [15:0] v);
    mem_txn(1'b0, 2'd0, v, 1, pc_m, 16'h0);
    ir_ld = 1'b1;
    tick();
    ir_ld = 1'b0;
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] v);
    load_ir({4'b0, idx, 9'b0});
    mem_txn(1'b0, 2'd0, v, 1, pc_m, 16'h0);
    rf_w_en = 1'b1; rf_w_addr_sel = 1'b1; rf_w_data_sel = 3'd2; rf_debug_addr = idx;
    tick();
    rf_w_en = 1'b0;
    chk("set_reg", 32'(rf_debug_data), 32'(v));
  endtask

  initial begin
    rst = 1'b1; pc_clr = 0; pc_inc = 0; pc_ld = 0; pc_sel = 0; ir_ld = 0;
    mem_start = 0; mem_we_sel = 0; mem_addr_sel = 0; rf_w_en = 0; rf_w_addr_sel = 0;
    rf_w_data_sel = 0; rf_r0_addr_sel = 0; nzp_ld = 0; alu_op = 0; alu_b_sel = 0;
    alu_start = 0; rf_debug_addr = 0; bus.mem_ack = 0; bus.mem_rdata = 0; pc_m = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_pc", 32'(pc_debug_data), 32'h0);
    chk("rst_ir", 32'(ir_out), 32'h0);
    chk("rst_req", 32'(bus.mem_req), 32'(0));
    chk("rst_we", 32'(bus.mem_we), 32'(0));
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mem_done", 32'(mem_done), 32'(0));
    chk("rst_alu_done", 32'(alu_done), 32'(0));
    chk("rst_r0", 32'(rf_debug_data), 32'h0);

    pc_inc = 1'b1;
    repeat (4) tick();
    pc_inc = 1'b0;
    pc_m = 16'h0004;
    chk("pc_inc4", 32'(pc_debug_data), 32'h4);

    // read with ack on third REQ cycle
    mem_txn(1'b0, 2'd0, 16'h1234, 3, 16'h0004, 16'h0);
    chk("read_idle_busy", 32'(busy), 32'(0));
    ir_ld = 1'b1;
    tick();
    ir_ld = 1'b0;
    chk("ir_from_mdr", 32'(ir_out), 32'h1234);

    // nzp reset value is 010
    load_ir(16'h0400);
    chk("nzp_rst_z", 32'(nzp_true), 32'(1));
    load_ir(16'h0A00);
    chk("nzp_rst_np", 32'(nzp_true), 32'(0));

    // store: addr = R1 + sext6(0x3F), data = R0 (ir[2:0] = 7)
    set_reg(3'd7, 16'hBEEF);
    set_reg(3'd2, 16'h0010);
    load_ir(16'h00BF);
    rf_r0_addr_sel = 1'b1;
    mem_txn(1'b1, 2'd3, 16'hDEAD, 2, 16'h000F, 16'hBEEF);
    rf_w_en = 1'b1; rf_w_addr_sel = 1'b1; rf_w_data_sel = 3'd2; rf_debug_addr = 3'd0;
    tick();
    rf_w_en = 1'b0;
    chk("store_mdr_kept", 32'(rf_debug_data), 32'h00BF);

    // multiply 0x0123 * 0x0045, with a stray alu_start mid-run
    set_reg(3'd2, 16'h0123);
    set_reg(3'd3, 16'h0045);
    load_ir(16'h0083);
    rf_r0_addr_sel = 1'b1; alu_b_sel = 1'b0; alu_op = 3'd4; alu_start = 1'b1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      chk("mul1_no_done", 32'(alu_done), 32'(0));
      chk("mul1_busy", 32'(busy), 32'(1));
      alu_start = (c == 5);
      tick();
    end
    alu_start = 1'b0;
    chk("mul1_done_c17", 32'(alu_done), 32'(1));
    chk("mul1_busy_clr", 32'(busy), 32'(0));
    rf_w_en = 1'b1; rf_w_addr_sel = 1'b1; rf_w_data_sel = 3'd4; rf_debug_addr = 3'd0;
    tick();
    rf_w_en = 1'b0;
    chk("mul1_result", 32'(rf_debug_data), 32'h4E6F);
    chk("mul1_done_pulse", 32'(alu_done), 32'(0));

    // 0xFFFF * 0xFFFF keeps low 16 bits
    set_reg(3'd2, 16'hFFFF);
    set_reg(3'd3, 16'hFFFF);
    load_ir(16'h0083);
    alu_op = 3'd4; alu_b_sel = 1'b0; alu_start = 1'b1;
    tick();
    alu_start = 1'b0;
    cyc = 1;
    while (!alu_done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("mul2_latency", 32'(cyc), 32'(17));
    rf_w_en = 1'b1; rf_w_addr_sel = 1'b1; rf_w_data_sel = 3'd4; rf_debug_addr = 3'd0;
    tick();
    rf_w_en = 1'b0;
    chk("mul2_result", 32'(rf_debug_data), 32'h0001);

    // ADD 0x7FFF + 1 -> negative
    set_reg(3'd2, 16'h7FFF);
    load_ir(16'h0881);
    alu_op = 3'd1; alu_b_sel = 1'b1; rf_w_en = 1'b1; rf_w_addr_sel = 1'b1;
    rf_w_data_sel = 3'd0; nzp_ld = 1'b1; rf_debug_addr = 3'd4;
    tick();
    rf_w_en = 1'b0; nzp_ld = 1'b0;
    chk("add_result", 32'(rf_debug_data), 32'h8000);
    chk("add_n_true", 32'(nzp_true), 32'(1));

    // AND with imm 0 -> zero
    load_ir(16'h0480);
    alu_op = 3'd2; alu_b_sel = 1'b1; rf_w_en = 1'b1; rf_w_addr_sel = 1'b1;
    rf_w_data_sel = 3'd0; nzp_ld = 1'b1; rf_debug_addr = 3'd2;
    tick();
    rf_w_en = 1'b0; nzp_ld = 1'b0;
    chk("and_result", 32'(rf_debug_data), 32'h0000);
    chk("and_z_true", 32'(nzp_true), 32'(1));
    load_ir(16'h0A80);
    chk("and_np_false", 32'(nzp_true), 32'(0));

    // overlapping multiply (3*5) and a 20-cycle memory read
    set_reg(3'd2, 16'h0003);
    set_reg(3'd3, 16'h0005);
    load_ir(16'h0083);
    rf_r0_addr_sel = 1'b1; alu_b_sel = 1'b0; alu_op = 3'd4; alu_start = 1'b1;
    mem_start = 1'b1; mem_we_sel = 1'b0; mem_addr_sel = 2'd0;
    tick();
    alu_start = 1'b0; mem_start = 1'b0; bus.mem_rdata = 16'h5A5A;
    for (int c = 1; c <= 20; c++) begin
      chk("ovl_busy", 32'(busy), 32'(1));
      chk("ovl_req", 32'(bus.mem_req), 32'(1));
      chk("ovl_alu_done", 32'(alu_done), 32'(c == 17));
      bus.mem_ack = (c == 20);
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("ovl_mem_done", 32'(mem_done), 32'(1));
    chk("ovl_busy_resp", 32'(busy), 32'(1));
    rf_w_en = 1'b1; rf_w_addr_sel = 1'b1; rf_w_data_sel = 3'd4; nzp_ld = 1'b1; rf_debug_addr = 3'd0;
    tick();
    nzp_ld = 1'b0;
    chk("ovl_busy_end", 32'(busy), 32'(0));
    chk("ovl_mul_result", 32'(rf_debug_data), 32'h000F);
    rf_w_data_sel = 3'd2;
    tick();
    rf_w_en = 1'b0;
    chk("ovl_mdr", 32'(rf_debug_data), 32'h5A5A);

    // PC sources; inc+ld increments only
    pc_inc = 1'b1; pc_ld = 1'b1; pc_sel = 2'd2;
    tick();
    pc_inc = 1'b0;
    chk("pc_inc_over_ld", 32'(pc_debug_data), 32'h0005);
    tick();
    chk("pc_ld_r1", 32'(pc_debug_data), 32'h0003);
    pc_sel = 2'd0;
    tick();
    chk("pc_ld_sext9", 32'(pc_debug_data), 32'h0086);
    pc_sel = 2'd3; alu_op = 3'd1; alu_b_sel = 1'b1;
    tick();
    chk("pc_ld_alu", 32'(pc_debug_data), 32'h0006);
    pc_sel = 2'd1;
    tick();
    pc_ld = 1'b0;
    chk("pc_ld_sext11", 32'(pc_debug_data), 32'h0089);
    pc_m = 16'h0089;

    // reset in the middle of a memory transaction and a multiply
    alu_op = 3'd4; alu_b_sel = 1'b0; alu_start = 1'b1;
    mem_start = 1'b1; mem_we_sel = 1'b0; mem_addr_sel = 2'd0;
    tick();
    alu_start = 1'b0; mem_start = 1'b0;
    tick();
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
    tick();
    rst = 1'b0; bus.mem_ack = 1'b0;
    pc_m = 16'h0000;
    chk("mid_rst_req", 32'(bus.mem_req), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_pc", 32'(pc_debug_data), 32'h0);
    chk("mid_rst_mem_done", 32'(mem_done), 32'(0));
    any_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      any_done = any_done | mem_done | alu_done;
      tick();
    end
    chk("mid_rst_no_pulse", 32'(any_done), 32'(0));
    rf_debug_addr = 3'd3;
    chk("mid_rst_rf", 32'(rf_debug_data), 32'h0);
    load_ir(16'h0400);
    chk("mid_rst_nzp", 32'(nzp_true), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
